// File: rtl/vend_ctrl_multi_if.sv
// Request/response bundle between a vending front end and vend_ctrl_multi.
// The master drives coins, loads and requests; the slave returns balance and bursts.
interface vend_ctrl_multi_if #(
    parameter int PRICE_W = 6,
    parameter int BAL_W   = 9,
    parameter int STOCK_W = 4,
    parameter int SELL_W  = 6,
    parameter int IDX_W   = 4
);
    logic               in_item_valid;
    logic [PRICE_W-1:0] in_item_price;
    logic [STOCK_W-1:0] in_item_stock;
    logic               in_coin_valid;
    logic [5:0]         in_coin;
    logic               in_rtn_coin;
    logic [IDX_W-1:0]   in_buy_item;
    logic [BAL_W-1:0]   out_monitor;
    logic               out_busy;
    logic               out_valid;
    logic [3:0]         out_consumer;
    logic [SELL_W-1:0]  out_sell_num;
    logic [1:0]         out_err;

    modport master (
        output in_item_valid, in_item_price, in_item_stock, in_coin_valid,
               in_coin, in_rtn_coin, in_buy_item,
        input  out_monitor, out_busy, out_valid, out_consumer, out_sell_num, out_err
    );

    modport slave (
        input  in_item_valid, in_item_price, in_item_stock, in_coin_valid,
               in_coin, in_rtn_coin, in_buy_item,
        output out_monitor, out_busy, out_valid, out_consumer, out_sell_num, out_err
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Vending controller: item slots with stock, coin balance, buy/return requests
// answered by a status / greedy-change / sold-count burst.
module vend_ctrl_multi #(
    parameter int N_ITEMS = 6,
    parameter int PRICE_W = 6,
    parameter int BAL_W   = 9,
    parameter int STOCK_W = 4,
    parameter int SELL_W  = 6,
    parameter int IDX_W   = 4
) (
    input logic           clk,
    input logic           rst_n,
    vend_ctrl_multi_if.slave bus
);
    localparam int               B         = (N_ITEMS > 6) ? N_ITEMS : 6;
    localparam logic [BAL_W-1:0] BAL_MAX   = {BAL_W{1'b1}};
    localparam logic [IDX_W-1:0] N_IDX     = IDX_W'(N_ITEMS);
    localparam logic [4:0]       LAST_BEAT = 5'(B);
    localparam logic [1:0]       ERR_COIN  = 2'd1;
    localparam logic [1:0]       ERR_FUNDS = 2'd2;
    localparam logic [1:0]       ERR_STOCK = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_BURST} state_t;
    state_t state, state_nxt;

    logic [PRICE_W-1:0] price [N_ITEMS];
    logic [STOCK_W-1:0] stock [N_ITEMS];
    logic [SELL_W-1:0]  sold  [N_ITEMS];
    logic [IDX_W-1:0]   load_cnt;
    logic [BAL_W-1:0]   balance;
    logic [BAL_W-1:0]   change_p0;
    logic               status_p0;
    logic [3:0]         cnt_p1 [5];
    logic [4:0]         beat;

    logic               req_load, req_coin, req_rtn, req_buy;
    logic [PRICE_W-1:0] sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic               idx_ok, funds_ok, buy_ok, coin_ok;
    logic [BAL_W:0]     coin_sum;
    logic [19:0]        split;
    logic [4:0]         k;
    logic [3:0]         beat_cons;
    logic [SELL_W-1:0]  beat_sell;

    function automatic logic [SELL_W-1:0] sat_inc(input logic [SELL_W-1:0] v);
        return (v == {SELL_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Counts packed as {n50, n20, n10, n5, n1}; each field holds the worst case for BAL_W=9.
    function automatic logic [19:0] greedy_split(input logic [BAL_W-1:0] amt);
        logic [BAL_W-1:0] r, n50, n20, n10, n5;
        r   = amt;
        n50 = r / BAL_W'(50);
        r   = r % BAL_W'(50);
        n20 = r / BAL_W'(20);
        r   = r % BAL_W'(20);
        n10 = r / BAL_W'(10);
        r   = r % BAL_W'(10);
        n5  = r / BAL_W'(5);
        r   = r % BAL_W'(5);
        return {4'(n50), 4'(n20), 4'(n10), 4'(n5), 4'(r)};
    endfunction

    assign req_load = (state == S_IDLE) && bus.in_item_valid;
    assign req_coin = (state == S_IDLE) && !bus.in_item_valid && bus.in_coin_valid;
    assign req_rtn  = (state == S_IDLE) && !bus.in_item_valid && !bus.in_coin_valid
                      && bus.in_rtn_coin;
    assign req_buy  = (state == S_IDLE) && !bus.in_item_valid && !bus.in_coin_valid
                      && !bus.in_rtn_coin && (bus.in_buy_item != '0);

    assign coin_sum = {1'b0, balance} + (BAL_W+1)'(bus.in_coin);
    assign coin_ok  = (coin_sum <= {1'b0, BAL_MAX});
    assign split    = greedy_split(change_p0);

    always_comb begin
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (bus.in_buy_item == IDX_W'(i + 1)) begin
                sel_price = price[i];
                sel_stock = stock[i];
            end
        end
        idx_ok   = (bus.in_buy_item <= N_IDX) && (sel_stock != '0);
        funds_ok = (balance >= BAL_W'(sel_price));
        buy_ok   = idx_ok && funds_ok;
    end

    // Beat 0 is produced while in CALC, later beats from the running beat counter.
    always_comb begin
        k         = (state == S_CALC) ? 5'd0 : beat;
        beat_cons = '0;
        beat_sell = '0;
        case (k)
            5'd0:    beat_cons = {3'b000, status_p0};
            5'd1:    beat_cons = cnt_p1[0];
            5'd2:    beat_cons = cnt_p1[1];
            5'd3:    beat_cons = cnt_p1[2];
            5'd4:    beat_cons = cnt_p1[3];
            5'd5:    beat_cons = cnt_p1[4];
            default: beat_cons = '0;
        endcase
        for (int i = 0; i < N_ITEMS; i++) begin
            if (k == 5'(i)) beat_sell = sold[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_rtn || req_buy) state_nxt = S_CALC;
            S_CALC:  state_nxt = S_BURST;
            S_BURST: if (beat == LAST_BEAT) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                price[i] <= '0;
                stock[i] <= '0;
                sold[i]  <= '0;
            end
            for (int i = 0; i < 5; i++) cnt_p1[i] <= '0;
            load_cnt         <= '0;
            balance          <= '0;
            change_p0        <= '0;
            status_p0        <= 1'b0;
            beat             <= '0;
            bus.out_busy     <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_consumer <= '0;
            bus.out_sell_num <= '0;
            bus.out_err      <= '0;
        end else begin
            bus.out_err <= '0;
            case (state)
                // Request stage: loads, coins and request capture into change_p0/status_p0
                S_IDLE: begin
                    if (req_load) begin
                        if (load_cnt < N_IDX) begin
                            for (int i = 0; i < N_ITEMS; i++) begin
                                if (load_cnt == IDX_W'(i)) begin
                                    price[i] <= bus.in_item_price;
                                    stock[i] <= bus.in_item_stock;
                                end
                                sold[i] <= '0;
                            end
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end else if (req_coin) begin
                        load_cnt <= '0;
                        if (coin_ok) balance <= coin_sum[BAL_W-1:0];
                        else         bus.out_err <= ERR_COIN;
                    end else if (req_rtn) begin
                        change_p0    <= balance;
                        status_p0    <= 1'b1;
                        balance      <= '0;
                        bus.out_busy <= 1'b1;
                    end else if (req_buy) begin
                        balance      <= '0;
                        bus.out_busy <= 1'b1;
                        if (buy_ok) begin
                            change_p0 <= balance - BAL_W'(sel_price);
                            status_p0 <= 1'b1;
                            for (int i = 0; i < N_ITEMS; i++) begin
                                if (bus.in_buy_item == IDX_W'(i + 1)) begin
                                    stock[i] <= stock[i] - 1'b1;
                                    sold[i]  <= sat_inc(sold[i]);
                                end
                            end
                        end else begin
                            change_p0   <= balance;
                            status_p0   <= 1'b0;
                            bus.out_err <= idx_ok ? ERR_FUNDS : ERR_STOCK;
                        end
                    end
                end
                // Split stage: coin counts into cnt_p1, first beat launched
                S_CALC: begin
                    cnt_p1[0]        <= split[19:16];
                    cnt_p1[1]        <= split[15:12];
                    cnt_p1[2]        <= split[11:8];
                    cnt_p1[3]        <= split[7:4];
                    cnt_p1[4]        <= split[3:0];
                    bus.out_valid    <= 1'b1;
                    bus.out_consumer <= beat_cons;
                    bus.out_sell_num <= beat_sell;
                    beat             <= 5'd1;
                end
                // Burst stage: one beat per cycle, then release busy
                S_BURST: begin
                    if (beat == LAST_BEAT) begin
                        bus.out_valid    <= 1'b0;
                        bus.out_consumer <= '0;
                        bus.out_sell_num <= '0;
                        bus.out_busy     <= 1'b0;
                        beat             <= '0;
                    end else begin
                        bus.out_consumer <= beat_cons;
                        bus.out_sell_num <= beat_sell;
                        beat             <= beat + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_monitor = balance;
endmodule
